// File: rtl/shift_mult_scheduler_pkg.sv
// Shared types and helpers for the shift-add multiplier scheduler.
// Holds the FSM state encoding and the ceil-log2 helper used to size and check ids.
package shift_mult_scheduler_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

endpackage

// File: rtl/shift_mult_scheduler_if.sv
// Request/response bundle between compute clients (master) and the scheduler (slave).
interface shift_mult_scheduler_if #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned REQ_NUM  = 4,
  parameter int unsigned ID_WIDTH = 2
);

  logic [REQ_NUM-1:0]       req_valid;
  logic [REQ_NUM-1:0]       req_ready;
  logic [REQ_NUM*WIDTH-1:0] req_mult1;
  logic [REQ_NUM*WIDTH-1:0] req_mult2;
  logic                     resp_valid;
  logic                     resp_ready;
  logic [ID_WIDTH-1:0]      resp_id;
  logic [2*WIDTH-1:0]       resp_product;
  logic                     busy;

  modport master (
    output req_valid, req_mult1, req_mult2, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_product, busy
  );

  modport slave (
    input  req_valid, req_mult1, req_mult2, resp_ready,
    output req_ready, resp_valid, resp_id, resp_product, busy
  );

endinterface

// File: rtl/shift_mult_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above ptr, wrapping.
// Produces a one-hot grant and its binary index; all zero when disabled or idle.
module shift_mult_scheduler_rr_arbiter #(
  parameter int unsigned REQ_NUM  = 4,
  parameter int unsigned ID_WIDTH = 2
) (
  input  logic [REQ_NUM-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  input  logic                enable,
  output logic [REQ_NUM-1:0]  grant,
  output logic [ID_WIDTH-1:0] grant_idx
);

  logic                found;
  logic [ID_WIDTH-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int unsigned k = 0; k < REQ_NUM; k++) begin
      cand = ID_WIDTH'((32'(ptr) + k) % REQ_NUM);
      if (enable && !found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/shift_mult_scheduler.sv
// Round-robin front end sharing one iterative shift-add multiplier among REQ_NUM clients.
// One shift-add step per multiplier bit; the product is returned tagged with the owner id.
module shift_mult_scheduler
  import shift_mult_scheduler_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned REQ_NUM  = 4,
  parameter int unsigned ID_WIDTH = 2
) (
  input logic                 clk,
  input logic                 rst,
  shift_mult_scheduler_if.slave bus
);

  localparam int unsigned ProdW = 2 * WIDTH;
  localparam int unsigned CntW  = (WIDTH > 1) ? clog2(WIDTH) : 1;

  if (ID_WIDTH != clog2(REQ_NUM) || REQ_NUM < 2) begin : g_bad_param
    $error("shift_mult_scheduler: ID_WIDTH must equal clog2(REQ_NUM) and REQ_NUM >= 2");
  end

  state_e              state_q, state_d;
  logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]    op1_q, op1_d;
  logic [WIDTH-1:0]    op2_q, op2_d;
  logic [ProdW-1:0]    acc_q, acc_d;

  logic [REQ_NUM-1:0]  grant;
  logic [ID_WIDTH-1:0] grant_idx;
  logic                arb_en;
  logic [WIDTH-1:0]    sel_mult1, sel_mult2;

  // Reset also masks grants so req_ready reads zero while rst is held.
  assign arb_en = (state_q == StIdle) && !rst;

  shift_mult_scheduler_rr_arbiter #(
    .REQ_NUM  (REQ_NUM),
    .ID_WIDTH (ID_WIDTH)
  ) u_arb (
    .req       (bus.req_valid),
    .ptr       (rr_ptr_q),
    .enable    (arb_en),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    sel_mult1 = '0;
    sel_mult2 = '0;
    for (int unsigned i = 0; i < REQ_NUM; i++) begin
      if (grant_idx == ID_WIDTH'(i)) begin
        sel_mult1 = bus.req_mult1[i*WIDTH +: WIDTH];
        sel_mult2 = bus.req_mult2[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    cnt_d    = cnt_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    acc_d    = acc_q;
    unique case (state_q)
      StIdle: begin
        if (|grant) begin
          op1_d    = sel_mult1;
          op2_d    = sel_mult2;
          id_d     = grant_idx;
          acc_d    = '0;
          cnt_d    = '0;
          rr_ptr_d = (grant_idx == ID_WIDTH'(REQ_NUM - 1)) ? '0 : grant_idx + ID_WIDTH'(1);
          state_d  = StCalc;
        end
      end
      StCalc: begin
        if (op2_q[cnt_q]) acc_d = acc_q + (ProdW'(op1_q) << cnt_q);
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) state_d = StDone;
      end
      StDone: begin
        if (bus.resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
      id_q     <= '0;
      cnt_q    <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      acc_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      cnt_q    <= cnt_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      acc_q    <= acc_d;
    end
  end

  assign bus.req_ready    = grant;
  assign bus.resp_valid   = (state_q == StDone);
  assign bus.resp_product = acc_q;
  assign bus.resp_id      = id_q;
  assign bus.busy         = (state_q != StIdle);

endmodule

// File: tb/tb_shift_mult_scheduler.sv
// Scoreboard bench for shift_mult_scheduler: expected (id, product) pairs are queued from a
// transaction-level round-robin model; a negedge monitor pops and compares each response.
module tb_shift_mult_scheduler;

  localparam int W  = 4;
  localparam int N  = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  shift_mult_scheduler_if #(.WIDTH(W), .REQ_NUM(N), .ID_WIDTH(IW)) bus ();

  shift_mult_scheduler #(
    .WIDTH    (W),
    .REQ_NUM  (N),
    .ID_WIDTH (IW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IW-1:0]  id;
    logic [2*W-1:0] prod;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   model_ptr = 0;
  bit   rr_rand = 1'b0;

  // Per-requester plan for one round: pn transactions with operands pm1/pm2[k].
  int         pn[N];
  int         pk[N];
  logic [W-1:0] pm1[N][4];
  logic [W-1:0] pm2[N][4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    n_chk++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
  endtask

  // Protocol monitor and scoreboard consumer.
  logic          prev_v = 1'b0, prev_r = 1'b0;
  logic [2*W-1:0] prev_p;
  logic [IW-1:0]  prev_id;
  int            acc_cyc = 0;
  bit            acc_pend = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_v   = 1'b0;
      prev_r   = 1'b0;
      acc_pend = 1'b0;
    end else begin
      chk("req_ready_onehot0", int'($onehot0(bus.req_ready)), 1);
      chk("req_ready_subset_of_valid", int'(bus.req_ready & ~bus.req_valid), 0);
      if (bus.busy) chk("req_ready_zero_when_busy", int'(bus.req_ready), 0);
      if (|(bus.req_valid & bus.req_ready)) begin
        acc_cyc  = cyc + 1;
        acc_pend = 1'b1;
      end
      if (prev_v && prev_r) chk("resp_valid_drops_after_accept", int'(bus.resp_valid), 0);
      if (bus.resp_valid && !prev_v) begin
        chk("resp_has_accept", int'(acc_pend), 1);
        chk("resp_latency", cyc - acc_cyc, W);
        acc_pend = 1'b0;
      end
      if (bus.resp_valid) chk("busy_in_done", int'(bus.busy), 1);
      if (bus.resp_valid && prev_v && !prev_r) begin
        chk("hold_product", int'(bus.resp_product), int'(prev_p));
        chk("hold_id", int'(bus.resp_id), int'(prev_id));
      end
      if (bus.resp_valid && bus.resp_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL resp_unexpected: got id %0d product %0h, expected no response",
                   bus.resp_id, bus.resp_product);
        end else begin
          e = exp_q.pop_front();
          chk("resp_id", int'(bus.resp_id), int'(e.id));
          chk("resp_product", int'(bus.resp_product), int'(e.prod));
        end
      end
      prev_v  = bus.resp_valid;
      prev_r  = bus.resp_ready;
      prev_p  = bus.resp_product;
      prev_id = bus.resp_id;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rr_rand) bus.resp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic clear_plan();
    for (int i = 0; i < N; i++) begin
      pn[i] = 0;
      pk[i] = 0;
    end
  endtask

  // Model: grants served in cyclic order from the pointer, one per transaction.
  task automatic run_round(input int budget);
    int          used[N];
    int          ptr, total, c, j;
    bit          found, done;
    logic [N-1:0] hs;
    exp_t        e;
    ptr   = model_ptr;
    total = 0;
    for (int i = 0; i < N; i++) begin
      used[i] = 0;
      pk[i]   = 0;
      total  += pn[i];
    end
    for (int t = 0; t < total; t++) begin
      found = 1'b0;
      for (int off = 0; off < N; off++) begin
        j = (ptr + off) % N;
        if (!found && used[j] < pn[j]) begin
          e.id   = IW'(j);
          e.prod = (2*W)'(int'(pm1[j][used[j]]) * int'(pm2[j][used[j]]));
          exp_q.push_back(e);
          used[j]++;
          ptr   = (j + 1) % N;
          found = 1'b1;
        end
      end
    end
    model_ptr = ptr;
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i] = (pn[i] > 0);
      if (pn[i] > 0) begin
        bus.req_mult1[i*W +: W] = pm1[i][0];
        bus.req_mult2[i*W +: W] = pm2[i][0];
      end
    end
    c    = 0;
    done = 1'b0;
    while (!done && c < budget) begin
      @(negedge clk);
      hs = bus.req_valid & bus.req_ready;
      @(posedge clk);
      #1;
      c++;
      for (int i = 0; i < N; i++) begin
        if (hs[i]) begin
          pk[i]++;
          if (pk[i] >= pn[i]) bus.req_valid[i] = 1'b0;
          else begin
            bus.req_mult1[i*W +: W] = pm1[i][pk[i]];
            bus.req_mult2[i*W +: W] = pm2[i][pk[i]];
          end
        end
      end
      done = (bus.req_valid == '0) && (exp_q.size() == 0);
    end
    if (!done) begin
      n_chk++;
      $display("FAIL round_timeout: %0d responses outstanding, expected 0", exp_q.size());
      exp_q.delete();
      bus.req_valid = '0;
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_resp_valid", int'(bus.resp_valid), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_req_ready", int'(bus.req_ready), 0);
    chk("rst_resp_product", int'(bus.resp_product), 0);
    chk("rst_resp_id", int'(bus.resp_id), 0);
  endtask

  task automatic do_reset();
    bus.req_valid = '1;
    rst = 1'b1;
    #1;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #1;
    bus.req_valid = '0;
    rst = 1'b0;
    model_ptr = 0;
    exp_q.delete();
  endtask

  initial begin
    int c;
    bus.req_valid  = '0;
    bus.req_mult1  = '0;
    bus.req_mult2  = '0;
    bus.resp_ready = 1'b1;
    #1;
    do_reset();

    // Single request 15*15.
    clear_plan();
    pn[0] = 1; pm1[0][0] = 4'hF; pm2[0][0] = 4'hF;
    run_round(40);

    // All four requesting; requester 0 twice to see the wrap.
    do_reset();
    clear_plan();
    for (int i = 0; i < N; i++) begin
      pn[i] = (i == 0) ? 2 : 1;
      for (int k = 0; k < 2; k++) begin
        pm1[i][k] = W'(i + 1);
        pm2[i][k] = 4'h3;
      end
    end
    run_round(80);

    // Backpressure: result held three cycles while requester 2 waits.
    do_reset();
    clear_plan();
    pn[0] = 1; pm1[0][0] = 4'h7; pm2[0][0] = 4'h6;
    pn[2] = 1; pm1[2][0] = 4'h3; pm2[2][0] = 4'h5;
    bus.resp_ready = 1'b0;
    fork
      run_round(80);
      begin
        c = 0;
        @(negedge clk);
        while (!bus.resp_valid && c < 40) begin
          @(negedge clk);
          c++;
        end
        for (int k = 0; k < 3; k++) begin
          if (k > 0) @(negedge clk);
          chk("bp_resp_valid", int'(bus.resp_valid), 1);
          chk("bp_req_ready", int'(bus.req_ready), 0);
          chk("bp_product", int'(bus.resp_product), 8'h2A);
        end
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b1;
      end
    join

    // Zero and edge operands.
    clear_plan();
    pn[0] = 1; pm1[0][0] = 4'hA; pm2[0][0] = 4'h0;
    run_round(40);
    clear_plan();
    pn[1] = 1; pm1[1][0] = 4'h1; pm2[1][0] = 4'h8;
    run_round(40);

    // Reset during the second CALC cycle; requester 3 must then be served cleanly.
    bus.req_valid[1]      = 1'b1;
    bus.req_mult1[1*W +: W] = 4'h5;
    bus.req_mult2[1*W +: W] = 4'h5;
    c = 0;
    @(negedge clk);
    while (!bus.req_ready[1] && c < 20) begin
      @(negedge clk);
      c++;
    end
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    @(posedge clk);
    #1;
    bus.req_valid[3] = 1'b1;
    rst = 1'b1;
    #1;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_ptr = 0;
    exp_q.delete();
    clear_plan();
    pn[3] = 1; pm1[3][0] = 4'h9; pm2[3][0] = 4'hD;
    run_round(40);

    // Pointer fairness: after requester 1, requester 2 wins over 0.
    do_reset();
    clear_plan();
    pn[1] = 1; pm1[1][0] = 4'h2; pm2[1][0] = 4'h2;
    run_round(40);
    clear_plan();
    pn[0] = 1; pm1[0][0] = 4'h4; pm2[0][0] = 4'h5;
    pn[2] = 1; pm1[2][0] = 4'hB; pm2[2][0] = 4'h3;
    run_round(60);

    // Randomized rounds with random backpressure.
    rr_rand = 1'b1;
    for (int r = 0; r < 25; r++) begin
      clear_plan();
      for (int i = 0; i < N; i++) begin
        pn[i] = $urandom_range(0, 2);
        for (int k = 0; k < 4; k++) begin
          pm1[i][k] = W'($urandom_range(0, 15));
          pm2[i][k] = W'($urandom_range(0, 15));
        end
      end
      run_round(400);
    end
    rr_rand = 1'b0;
    bus.resp_ready = 1'b1;
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/shift_mult_scheduler.md
Name: shift_mult_scheduler

Overview:
Round-robin scheduler that shares one iterative shift-add multiplier among REQ_NUM requesters.
- Arbitrates operand requests and latches the granted operands.
- Sequences one shift-add step per bit of the multiplier.
- Returns the product tagged with the requester id.
- Sits between multiple compute clients and the shift-add multiplier datapath.

Parameters:
WIDTH, 4, operand width in bits; product is 2*WIDTH bits.
REQ_NUM, 4, number of requesters (>=2).
ID_WIDTH, 2, requester id width; must equal clog2(REQ_NUM).

Ports:
clk  input  1  clock; single clock domain.
rst  input  1  asynchronous reset, active-high.
req_valid  input  REQ_NUM  per-requester operand valid.
req_ready  output  REQ_NUM  per-requester grant/accept; at most one bit high.
req_mult1  input  REQ_NUM*WIDTH  multiplicand; requester i at [i*WIDTH +: WIDTH].
req_mult2  input  REQ_NUM*WIDTH  multiplier; same packing as req_mult1.
resp_valid  output  1  product valid.
resp_ready  input  1  consumer accepts the product.
resp_id  output  ID_WIDTH  index of the requester that owns the product.
resp_product  output  2*WIDTH  unsigned product mult1*mult2.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE, rr_ptr=0, cnt=0, acc=0.
  - resp_valid=0, resp_id=0, resp_product=0, busy=0, req_ready=0.
- FSM states IDLE, CALC, DONE.
- IDLE:
  - Grant goes to the first i with req_valid[i]=1, searching from rr_ptr upward with wrap at REQ_NUM-1 -> 0.
  - req_ready[grant]=1 is combinational from req_valid and rr_ptr, and is asserted only in IDLE.
  - Handshake completes when req_valid[i] && req_ready[i] at a clock edge.
  - On handshake:
    - Latch op1=mult1[i], op2=mult2[i], id=i.
    - acc=0, cnt=0.
    - rr_ptr = (i+1) mod REQ_NUM.
    - Go to CALC.
  - With no req_valid: stay in IDLE; rr_ptr unchanged.
- CALC:
  - Runs for exactly WIDTH cycles.
  - Each cycle: if op2[cnt]=1 then acc += op1<<cnt, computed at 2*WIDTH bits (no overflow is possible). Then cnt++.
  - When cnt==WIDTH-1 the last step executes and the state moves to DONE.
  - req_ready is all zero and req_valid is ignored throughout CALC.
- DONE:
  - resp_valid=1; resp_product=acc and resp_id=id, both held stable until handshake.
  - On resp_valid && resp_ready: resp_valid drops next cycle and the state returns to IDLE.
  - No new grant is issued in the DONE cycle.
- Latency and throughput:
  - Request accepted at edge T gives resp_valid high from edge T+WIDTH.
  - Best-case issue interval is WIDTH+2 cycles.
- Requester rules:
  - A requester must hold req_valid and its operands stable until granted.
  - Dropping req_valid before grant is legal; that requester is simply not granted.
- Simultaneous requests: only one grant per IDLE cycle; the others keep waiting. The rotating rr_ptr prevents starvation.
- Reset mid-operation (CALC or DONE): the in-flight result is discarded, no resp_valid is issued, and rr_ptr returns to 0.
- Operand zero: the full WIDTH cycles are still spent, giving a fixed latency.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE/CALC/DONE;
  - clog2 function used to derive and check ID_WIDTH.
- Sub-module rr_arbiter (REQ_NUM):
  - inputs: req vector, ptr, enable;
  - outputs: one-hot grant and binary grant index;
  - purely combinational.
- Top-level holds the FSM, counter, operand/accumulator registers and the response register.

Test Plan:
- Single request: req 0, mult1=4'hF, mult2=4'hF, resp_ready=1.
  - Expect resp_product=8'hE1, resp_id=0.
  - resp_valid rises exactly 4 cycles after the accept edge and stays high one cycle.
- Round-robin: all four req_valid held high, mult1=i+1, mult2=4'h3.
  - Grant order 0,1,2,3,0.
  - Products 3,6,9,12 with matching resp_id; never two req_ready bits high.
- Backpressure: resp_ready low 3 cycles in DONE with product 8'h2A (mult1=7, mult2=6).
  - resp_valid, resp_product and resp_id stay stable; req_ready stays 0.
  - Result is accepted on the 4th cycle, then IDLE.
- Zero and edge operands: (4'hA, 4'h0) -> 8'h00; (4'h1, 4'h8) -> 8'h08. Both take the full 4-cycle latency.
- Reset in CALC: assert rst at cycle 2 of CALC.
  - Outputs go to their reset values immediately; no resp_valid ever appears for that operation.
  - After rst release, requester 3 alone is granted and its result is correct.
- Pointer fairness: req 1 granted, then req 0 and req 2 both valid.
  - Req 2 is granted before req 0 (rr_ptr=2).
